mem_arbiter_2p: RTL and testbench
=================================

Name: mem_arbiter_2p

Overview:
- Two-requester arbiter and sequencer for the team's 64x8 single-port memory. That memory has a registered DOUT, an active-low REN and a level-sensitive write when REN=1 and WEN=0.
- Grants one requester at a time with round-robin priority, drives the memory control signals, captures read data and returns a one-cycle ack.
- Sits between two client FSMs and the memory instance.

Parameters:
ADDR_W, 6, memory address width
DATA_W, 8, memory data width

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request, held until ack0
we0  input  1  requester 0 op, 1=write, 0=read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  DATA_W  requester 0 read data, valid while ack0=1, held afterwards
req1/we1/addr1/wdata1  input  1/1/ADDR_W/DATA_W  requester 1, same meaning as requester 0
ack1  output  1  one-cycle completion pulse to requester 1
rdata1  output  DATA_W  requester 1 read data, same rules as rdata0
mem_ren  output  1  to memory REN, active-low read enable
mem_wen  output  1  to memory WEN, active-low write enable
mem_addr  output  ADDR_W  to memory ADDR
mem_din  output  DATA_W  to memory DIN
mem_dout  input  DATA_W  from memory DOUT
busy  output  1  high in every state except IDLE
owner  output  1  id of the requester currently granted; meaningful only while busy=1

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE, prio=0.
  - ack0=ack1=0, rdata0=rdata1=0.
  - Command registers cleared; owner=0.
  - mem_ren=1, mem_wen=1, mem_addr=0, mem_din=0.
- State encoding: IDLE=2'b00, ISSUE=2'b01, RDWAIT=2'b10, DONE=2'b11.
- Output timing: mem_* outputs and ack* are decoded only from state and registered command fields. No combinational path from any req/addr/wdata input to any output.
- IDLE:
  - mem_ren=1, mem_wen=1.
  - If exactly one req is high, that requester wins. If both are high, the requester equal to prio wins.
  - On the edge, latch the winner's we/addr/wdata into cmd_we/cmd_addr/cmd_wdata, set owner=winner, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (1 cycle), mem_addr=cmd_addr:
  - Read: mem_ren=0, mem_wen=1. The memory registers MEM[cmd_addr] onto DOUT at the closing edge. Next state RDWAIT.
  - Write: mem_ren=1, mem_wen=0, mem_din=cmd_wdata. Next state DONE.
- RDWAIT (1 cycle):
  - mem_ren=1, mem_wen=1; mem_dout carries the read data during this cycle.
  - At the closing edge, capture mem_dout into rdata[owner]. This is the same edge at which the memory zeroes DOUT, so the register must sample the pre-edge value.
  - Next state DONE.
- DONE (1 cycle):
  - ack[owner]=1, the other ack=0; mem_ren=mem_wen=1.
  - At the closing edge, prio <= ~owner, go to IDLE.
- Latency, counted from the IDLE edge that grants to the ack cycle:
  - Read: ack high in the 3rd cycle after the grant edge.
  - Write: ack high in the 2nd cycle after the grant edge.
  - Minimum request-to-request spacing: read 4 cycles, write 3 cycles.
- Requester rules:
  - req must stay high until ack.
  - Changes to we/addr/wdata after the grant edge are ignored, because the command is latched.
  - req still high in the IDLE cycle after its ack is treated as a new request.
  - A losing requester simply waits; its inputs are not sampled until it wins.
- rdata of the non-owner requester never changes. rdata is not updated on writes.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…
- Reset mid-operation:
  - Any in-flight transaction is abandoned with no ack.
  - A write in ISSUE is cut short: mem_wen returns to 1 asynchronously, and the memory content at cmd_addr is undefined.

Test Plan:
- Reset, then req1=1, we1=1, addr1=6'd5, wdata1=8'hA5 -> mem_wen=0 for exactly 1 cycle with mem_addr=5; ack1 pulses 2 cycles after the grant edge; rdata1 stays 0.
- After that write, req0=1, we0=0, addr0=5 -> mem_ren=0 for 1 cycle; ack0 pulses in the 3rd cycle after the grant edge with rdata0=8'hA5; rdata1 unchanged.
- req0 and req1 both high at the same edge after reset, reads of addr 1 and 2 -> requester 0 served first (prio=0), requester 1 second; owner goes 0 then 1; ack0 precedes ack1 by 4 cycles.
- Both requesters held high for 6 transactions -> ack order 0,1,0,1,0,1; busy is low for exactly one IDLE cycle between transactions.
- Grant requester 0 on a read of addr 3, then change addr0 to 4 during ISSUE -> mem_addr stays 3, rdata0=MEM[3].
- Assert RESET=0 during RDWAIT of a read -> state=IDLE, mem_ren=mem_wen=1 and ack0=ack1=0 immediately (async); no ack occurs after reset release; the next request completes normally with prio=0.

Source files
------------

// File: rtl/mem_arbiter_2p.sv
// -----------------------------------------------------------------------------
// mem_arbiter_2p
//
// Two-requester round-robin arbiter and sequencer in front of a 64x8
// single-port memory (registered DOUT, active-low REN, level-sensitive write
// while REN=1 and WEN=0). One requester is granted at a time; the granted
// command is latched, played out on the memory pins, read data is captured,
// and a one-cycle ack is returned to the owner.
//
// Ports:
//   CLK                     clock, rising edge
//   RESET                   asynchronous, active-low reset
//   req0/we0/addr0/wdata0   requester 0 command (req held until ack0)
//   ack0, rdata0            requester 0 completion pulse and read data
//   req1/we1/addr1/wdata1   requester 1 command (req held until ack1)
//   ack1, rdata1            requester 1 completion pulse and read data
//   mem_ren, mem_wen        memory REN / WEN, active-low
//   mem_addr, mem_din       memory ADDR / DIN
//   mem_dout                memory DOUT
//   busy                    high whenever the sequencer is not idle
//   owner                   granted requester id, meaningful while busy=1
//
// Every output is decoded from the state register and the latched command
// fields only, so no request-side input reaches an output combinationally.
// -----------------------------------------------------------------------------
module mem_arbiter_2p #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ISSUE  = 2'b01;
  localparam logic [1:0] RDWAIT = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              prio;
  logic              winner;
  logic              grant;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  assign grant = (state == IDLE) && (req0 || req1);

  always_comb begin
    // NOTE: assign a default before any conditional update so every path
    // drives the signal and no latch is inferred.
    winner = prio;
    if (req0 && !req1) begin
      winner = 1'b0;
    end else if (req1 && !req0) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd_we ? DONE : RDWAIT;
      RDWAIT:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge
      // values; this is what lets the RDWAIT capture see mem_dout before the
      // memory clears DOUT on the very same edge.
      state <= state_nxt;

      if (grant) begin
        owner     <= winner;
        cmd_we    <= winner ? we1    : we0;
        cmd_addr  <= winner ? addr1  : addr0;
        cmd_wdata <= winner ? wdata1 : wdata0;
      end

      // Only the owner's read register moves, and only on reads.
      if (state == RDWAIT) begin
        if (owner) rdata1 <= mem_dout;
        else       rdata0 <= mem_dout;
      end

      // Hand priority to the other requester once this transaction retires.
      if (state == DONE) begin
        prio <= ~owner;
      end
    end
  end

  // Memory strobes are asserted only in ISSUE. Address and data follow the
  // latched command, which reset clears, so the pins read 0 out of reset.
  assign mem_ren  = !((state == ISSUE) && !cmd_we);
  assign mem_wen  = !((state == ISSUE) &&  cmd_we);
  assign mem_addr = cmd_addr;
  assign mem_din  = cmd_wdata;

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) && !owner;
  assign ack1 = (state == DONE) &&  owner;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_2p
//
// Self-checking bench for mem_arbiter_2p. A behavioural 64x8 memory sits on
// the memory pins. The reference model tracks each transaction as a phase
// count since its grant edge plus a reference memory image and predicts every
// output cycle by cycle. Inputs are driven and outputs sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_2p;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, busy, owner, mem_ren, mem_wen;
  logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  mem_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .req0    (req[0]),
    .we0     (we[0]),
    .addr0   (addr[0]),
    .wdata0  (wdata[0]),
    .ack0    (ack0),
    .rdata0  (rdata0),
    .req1    (req[1]),
    .we1     (we[1]),
    .addr1   (addr[1]),
    .wdata1  (wdata[1]),
    .ack1    (ack1),
    .rdata1  (rdata1),
    .mem_ren (mem_ren),
    .mem_wen (mem_wen),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_dout(mem_dout),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: registered DOUT, cleared when not reading; write is
  // level-sensitive while REN=1 and WEN=0.
  logic [DW-1:0] tb_mem [64] = '{default: '0};
  always @(posedge CLK) mem_dout <= !mem_ren ? tb_mem[mem_addr] : '0;
  always @(mem_ren, mem_wen, mem_addr, mem_din)
    if (mem_ren && !mem_wen) tb_mem[mem_addr] = mem_din;

  // Reference model
  int            m_phase;   // 0 idle, else cycles since grant edge
  bit            m_owner, m_we, m_prio;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [64] = '{default: '0};

  int mode [2];             // 0 drop req on ack, 1 hold req, 2 random client
  int cyc;
  int n_tests, n_fail;
  int ack_log [$];
  int ack_cyc [2];
  bit s_busy, s_ack0, s_ack1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_prio = 1'b0; m_owner = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic issue(input int i, input bit w, input int a, input int d);
    req[i] = 1'b1; we[i] = w; addr[i] = AW'(a); wdata[i] = DW'(d);
  endtask

  task automatic new_cmd(input int i);
    issue(i, 1'($urandom_range(1)), int'($urandom_range(63)), int'($urandom_range(255)));
  endtask

  // One clock: compare outputs, let clients react, advance model, next negedge.
  task automatic tick();
    bit acked [2];
    int lp;
    lp = m_we ? 2 : 3;
    check("busy", 32'(busy), 32'(m_phase != 0));
    if (m_phase != 0) check("owner", 32'(owner), 32'(m_owner));
    check("mem_ren", 32'(mem_ren), 32'(!(m_phase == 1 && !m_we)));
    check("mem_wen", 32'(mem_wen), 32'(!(m_phase == 1 && m_we)));
    if (m_phase == 1) begin
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) check("mem_din", 32'(mem_din), 32'(m_wdata));
    end
    for (int i = 0; i < 2; i++) acked[i] = (m_phase != 0) && (m_phase == lp) && (int'(m_owner) == i);
    check("ack0", 32'(ack0), 32'(acked[0]));
    check("ack1", 32'(ack1), 32'(acked[1]));
    check("rdata0", 32'(rdata0), 32'(m_rdata[0]));
    check("rdata1", 32'(rdata1), 32'(m_rdata[1]));
    s_busy = busy; s_ack0 = ack0; s_ack1 = ack1;
    if (ack0) begin ack_log.push_back(0); ack_cyc[0] = cyc; end
    if (ack1) begin ack_log.push_back(1); ack_cyc[1] = cyc; end

    for (int i = 0; i < 2; i++) begin
      case (mode[i])
        0: if (acked[i]) req[i] = 1'b0;
        2: begin
          if (acked[i]) begin
            if ($urandom_range(1) == 0) req[i] = 1'b0;
            else new_cmd(i);
          end else if (!req[i]) begin
            if ($urandom_range(2) == 0) new_cmd(i);
          end else if (m_phase != 0 && int'(m_owner) == i) begin
            // Owner fiddles with its inputs mid-transaction; must be ignored.
            we[i] = 1'($urandom_range(1));
            addr[i] = AW'($urandom_range(63));
            wdata[i] = DW'($urandom_range(255));
          end
        end
        default: ;
      endcase
    end

    if (m_phase == 0) begin
      if (req[0] || req[1]) begin
        m_owner = (req[0] && req[1]) ? m_prio : req[1];
        m_we    = we[m_owner];
        m_addr  = addr[m_owner];
        m_wdata = wdata[m_owner];
        m_phase = 1;
      end
    end else if (m_phase == lp) begin
      m_prio  = !m_owner;
      m_phase = 0;
    end else begin
      if (m_phase == 1 && m_we)  ref_mem[m_addr] = m_wdata;
      if (m_phase == 2 && !m_we) m_rdata[m_owner] = ref_mem[m_addr];
      m_phase++;
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((req[0] || req[1] || m_phase != 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain_done", 32'(req[0] || req[1] || m_phase != 0), 32'(0));
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) req[i] = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idle;
    bit started;
    n_tests = 0; n_fail = 0; cyc = 0;
    mode[0] = 0; mode[1] = 0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    model_reset();
    m_we = 1'b0; m_addr = '0; m_wdata = '0;

    // Reset values
    @(negedge CLK);
    check("rst_mem_ren", 32'(mem_ren), 32'(1));
    check("rst_mem_wen", 32'(mem_wen), 32'(1));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_din", 32'(mem_din), 32'(0));
    check("rst_ack0", 32'(ack0), 32'(0));
    check("rst_ack1", 32'(ack1), 32'(0));
    check("rst_rdata0", 32'(rdata0), 32'(0));
    check("rst_rdata1", 32'(rdata1), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    @(negedge CLK);
    RESET = 1'b1;

    // Write by requester 1, then read it back through requester 0
    issue(1, 1'b1, 5, 8'hA5);
    drain(20);
    check("wr_rdata1", 32'(rdata1), 32'(0));
    issue(0, 1'b0, 5, 0);
    drain(20);
    check("rd_rdata0", 32'(rdata0), 32'hA5);
    check("rd_rdata1_hold", 32'(rdata1), 32'(0));

    // Simultaneous reads right after reset: requester 0 first, 4 cycles apart
    do_reset();
    ack_log.delete();
    issue(0, 1'b0, 1, 0);
    issue(1, 1'b0, 2, 0);
    drain(30);
    check("both_acks", 32'(ack_log.size()), 32'(2));
    if (ack_log.size() >= 2) begin
      check("both_first", 32'(ack_log[0]), 32'(0));
      check("both_second", 32'(ack_log[1]), 32'(1));
    end
    check("both_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'(4));

    // Both held continuously: strict alternation, one idle cycle between
    ack_log.delete();
    mode[0] = 1; mode[1] = 1;
    issue(0, 1'b1, 10, 8'h10);
    issue(1, 1'b1, 11, 8'h11);
    n = 0; idle = 0; started = 1'b0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      tick();
      if (started && !s_busy) idle++;
      if (s_ack0 || s_ack1) begin n++; started = 1'b1; end
    end
    mode[0] = 0; mode[1] = 0;
    drain(30);
    check("fair_count", 32'(n), 32'(6));
    for (int k = 0; k < 6 && k < ack_log.size(); k++)
      check("fair_order", 32'(ack_log[k]), 32'(k % 2));
    check("fair_idle", 32'(idle), 32'(5));

    // Command latched at grant: change addr0 during ISSUE
    issue(0, 1'b1, 3, 8'h33); drain(20);
    issue(0, 1'b1, 4, 8'h44); drain(20);
    issue(0, 1'b0, 3, 0);
    tick();
    addr[0] = AW'(4);
    drain(20);
    check("latched_rdata0", 32'(rdata0), 32'h33);

    // Reset during RDWAIT; previous owner 0 leaves priority at 1 beforehand
    issue(0, 1'b1, 9, 8'h99); drain(20);
    issue(1, 1'b0, 3, 0);
    n = 0;
    while (m_phase != 2 && n < 20) begin tick(); n++; end
    check("reached_rdwait", 32'(m_phase), 32'(2));
    RESET = 1'b0;
    #1;
    check("async_mem_ren", 32'(mem_ren), 32'(1));
    check("async_mem_wen", 32'(mem_wen), 32'(1));
    check("async_ack0", 32'(ack0), 32'(0));
    check("async_ack1", 32'(ack1), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    model_reset();
    req[1] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    ack_log.delete();
    issue(0, 1'b0, 9, 0);
    issue(1, 1'b0, 3, 0);
    drain(30);
    check("post_rst_acks", 32'(ack_log.size()), 32'(2));
    if (ack_log.size() >= 1) check("post_rst_first", 32'(ack_log[0]), 32'(0));
    check("post_rst_rdata0", 32'(rdata0), 32'h99);

    // Randomized traffic against the model
    mode[0] = 2; mode[1] = 2;
    repeat (3000) tick();
    mode[0] = 0; mode[1] = 0;
    drain(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
